// File: rtl/flash_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_req_arbiter
// Description : Round-robin icache/dcache miss arbiter in front of the single
//               SPI flash read engine. Optional WAIT watchdog enabled by
//               defining FLASH_ARB_TIMEOUT_EN.
// Revision    : 1.1
// ============================================================================
module flash_req_arbiter #(
    parameter logic [19:0] MAX_ADDR       = 20'hAFFFF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        ic_req,
    input  logic [19:0] ic_addr,
    input  logic        dc_req,
    input  logic [19:0] dc_addr,
    output logic        ic_ack,
    output logic        dc_ack,
    output logic        ic_err,
    output logic        dc_err,
    output logic [31:0] rdata,
    output logic        spi_req,
    output logic [19:0] spi_addr,
    input  logic        spi_ready,
    input  logic [31:0] spi_data,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic c_GNT_IC = 1'b0;
    localparam logic c_GNT_DC = 1'b1;

    logic [2:0]  r_state, w_state;
    logic        r_grant, w_grant;
    logic        r_last_grant, w_last_grant;
    logic [19:0] r_spi_addr, w_spi_addr;
    logic [31:0] r_rdata, w_rdata;
    logic        r_spi_req, w_spi_req;
    logic        r_ic_ack, w_ic_ack, r_dc_ack, w_dc_ack;
    logic        r_ic_err, w_ic_err, r_dc_err, w_dc_err;
    logic        r_busy, w_busy;
    logic [19:0] w_req_addr;
    logic        w_timeout;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)                r_cnt <= '0;
        else if (r_state != S_WAIT) r_cnt <= '0;
        else                        r_cnt <= r_cnt + 1'b1;
    end

    assign w_timeout = (r_state == S_WAIT) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_grant      <= c_GNT_IC;
            r_last_grant <= c_GNT_DC;
            r_spi_addr   <= '0;
            r_rdata      <= '0;
            r_spi_req    <= 1'b0;
            r_ic_ack     <= 1'b0;
            r_dc_ack     <= 1'b0;
            r_ic_err     <= 1'b0;
            r_dc_err     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_grant      <= w_grant;
            r_last_grant <= w_last_grant;
            r_spi_addr   <= w_spi_addr;
            r_rdata      <= w_rdata;
            r_spi_req    <= w_spi_req;
            r_ic_ack     <= w_ic_ack;
            r_dc_ack     <= w_dc_ack;
            r_ic_err     <= w_ic_err;
            r_dc_err     <= w_dc_err;
            r_busy       <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_grant      = r_grant;
        w_last_grant = r_last_grant;
        w_spi_addr   = r_spi_addr;
        w_rdata      = r_rdata;
        w_req_addr   = ic_addr;
        case (r_state)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    if (ic_req && dc_req) begin
                        w_grant      = ~r_last_grant;
                        w_last_grant = ~r_last_grant;
                    end else begin
                        w_grant = dc_req ? c_GNT_DC : c_GNT_IC;
                    end
                    w_req_addr = (w_grant == c_GNT_DC) ? dc_addr : ic_addr;
                    if (w_req_addr > MAX_ADDR) begin
                        w_state = S_ERR;
                    end else begin
                        w_state    = S_ISSUE;
                        w_spi_addr = w_req_addr;
                    end
                end
            end
            S_ISSUE: w_state = S_WAIT;
            S_WAIT: begin
                if (spi_ready) begin
                    w_rdata = spi_data;
                    w_state = S_RESP;
                end else if (w_timeout) begin
                    w_state = S_ERR;
                end
            end
            S_RESP:  w_state = S_IDLE;
            S_ERR:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_spi_req = (w_state == S_ISSUE);
        w_ic_ack  = (w_state == S_RESP) && (w_grant == c_GNT_IC);
        w_dc_ack  = (w_state == S_RESP) && (w_grant == c_GNT_DC);
        w_ic_err  = (w_state == S_ERR)  && (w_grant == c_GNT_IC);
        w_dc_err  = (w_state == S_ERR)  && (w_grant == c_GNT_DC);
        w_busy    = (w_state != S_IDLE);
    end

    assign ic_ack   = r_ic_ack;
    assign dc_ack   = r_dc_ack;
    assign ic_err   = r_ic_err;
    assign dc_err   = r_dc_err;
    assign rdata    = r_rdata;
    assign spi_req  = r_spi_req;
    assign spi_addr = r_spi_addr;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_flash_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_req_arbiter
// Description : Vector table, hand-written corner sequences and a
//               transaction-level random model for flash_req_arbiter
//               (timeout checks when FLASH_ARB_TIMEOUT_EN is defined).
// Revision    : 1.1
// ============================================================================
module tb_flash_req_arbiter;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        ic_req = 1'b0, dc_req = 1'b0, spi_ready = 1'b0;
    logic [19:0] ic_addr = '0, dc_addr = '0;
    logic [31:0] spi_data = '0;
    logic        ic_ack, dc_ack, ic_err, dc_err, spi_req, busy;
    logic [31:0] rdata;
    logic [19:0] spi_addr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    flash_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .resetn(resetn),
        .ic_req(ic_req), .ic_addr(ic_addr), .dc_req(dc_req), .dc_addr(dc_addr),
        .ic_ack(ic_ack), .dc_ack(dc_ack), .ic_err(ic_err), .dc_err(dc_err),
        .rdata(rdata), .spi_req(spi_req), .spi_addr(spi_addr),
        .spi_ready(spi_ready), .spi_data(spi_data), .busy(busy)
    );

    typedef struct {
        logic        ic;
        logic [19:0] ia;
        logic        dc;
        logic [19:0] da;
        logic [31:0] data;
        int          dly;
        logic        exp_dc;
        logic        exp_err;
        logic [19:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic txn(input logic ic, input logic [19:0] ia, input logic dc, input logic [19:0] da,
                       input logic [31:0] data, input int dly, input logic exp_dc, input logic exp_err,
                       input logic [19:0] exp_addr, input logic [31:0] exp_rdata, input string tag);
        ic_req = ic; ic_addr = ia; dc_req = dc; dc_addr = da;
        tick();
        ic_req = 1'b0; dc_req = 1'b0;
        if (exp_err) begin
            chk({tag, " ic_err"}, 32'(ic_err), 32'(!exp_dc));
            chk({tag, " dc_err"}, 32'(dc_err), 32'(exp_dc));
            chk({tag, " no spi_req"}, 32'(spi_req), 32'd0);
            tick();
            chk({tag, " err drop"}, {30'd0, ic_err, dc_err}, 32'd0);
            chk({tag, " rdata kept"}, rdata, exp_rdata);
        end else begin
            chk({tag, " spi_req"}, 32'(spi_req), 32'd1);
            chk({tag, " spi_addr"}, 32'(spi_addr), 32'(exp_addr));
            chk({tag, " no err"}, {30'd0, ic_err, dc_err}, 32'd0);
            tick();
            chk({tag, " spi_req pulse"}, 32'(spi_req), 32'd0);
            for (int i = 0; i < dly; i++) begin
                chk({tag, " early ack"}, {30'd0, ic_ack, dc_ack}, 32'd0);
                tick();
            end
            spi_ready = 1'b1; spi_data = data;
            tick();
            spi_ready = 1'b0; spi_data = $urandom;
            chk({tag, " ic_ack"}, 32'(ic_ack), 32'(!exp_dc));
            chk({tag, " dc_ack"}, 32'(dc_ack), 32'(exp_dc));
            chk({tag, " rdata"}, rdata, exp_rdata);
        end
        tick();
        chk({tag, " idle"}, {28'd0, busy, ic_ack, dc_ack, spi_req}, 32'd0);
    endtask

    logic        m_last;
    logic [31:0] m_rdata;

    initial begin
        vecs[0] = '{1, 20'h00010, 0, 20'h0,     32'hDEADBEEF, 1, 0, 0, 20'h00010, 32'hDEADBEEF};
        vecs[1] = '{1, 20'h01000, 1, 20'h02000, 32'h11111111, 0, 0, 0, 20'h01000, 32'h11111111};
        vecs[2] = '{1, 20'h03000, 1, 20'h04000, 32'h22222222, 2, 1, 0, 20'h04000, 32'h22222222};
        vecs[3] = '{1, 20'h05000, 1, 20'h06000, 32'h33333333, 0, 0, 0, 20'h05000, 32'h33333333};
        vecs[4] = '{0, 20'h0,     1, 20'hB0000, 32'h99999999, 0, 1, 1, 20'h0,     32'h33333333};
        vecs[5] = '{0, 20'h0,     1, 20'hAFFFF, 32'h44444444, 3, 1, 0, 20'hAFFFF, 32'h44444444};
        vecs[6] = '{1, 20'hFFFFF, 0, 20'h0,     32'h99999999, 0, 0, 1, 20'h0,     32'h44444444};
        vecs[7] = '{1, 20'hB0000, 1, 20'h00020, 32'h55555555, 1, 1, 0, 20'h00020, 32'h55555555};
        vecs[8] = '{1, 20'h00030, 1, 20'hFFFFF, 32'h66666666, 0, 0, 0, 20'h00030, 32'h66666666};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset outputs", {26'd0, busy, ic_ack, dc_ack, ic_err, dc_err, spi_req}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i])
            txn(vecs[i].ic, vecs[i].ia, vecs[i].dc, vecs[i].da, vecs[i].data, vecs[i].dly,
                vecs[i].exp_dc, vecs[i].exp_err, vecs[i].exp_addr, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        m_last = 1'b0;
        m_rdata = 32'h66666666;

        spi_ready = 1'b1; spi_data = 32'hBADBAD00;
        tick();
        spi_ready = 1'b0;
        tick();
        chk("stray ready ack", {29'd0, busy, ic_ack, dc_ack}, 32'd0);
        chk("stray ready rdata", rdata, m_rdata);

        dc_req = 1'b1; dc_addr = 20'h00500;
        tick();
        chk("drop spi_addr", 32'(spi_addr), 32'h00500);
        dc_req = 1'b0;
        tick();
        ic_req = 1'b1; ic_addr = 20'h00600;
        tick();
        chk("drop wait", {30'd0, busy, spi_req}, 32'd2);
        spi_ready = 1'b1; spi_data = 32'h77777777;
        tick();
        spi_ready = 1'b0;
        chk("drop dc_ack", {30'd0, ic_ack, dc_ack}, 32'd1);
        chk("drop rdata", rdata, 32'h77777777);
        tick();
        chk("drop idle gap", {29'd0, busy, spi_req, dc_ack}, 32'd0);
        tick();
        chk("drop ic granted", {11'd0, spi_req, spi_addr}, {11'd0, 1'b1, 20'h00600});
        ic_req = 1'b0;
        tick();
        spi_ready = 1'b1; spi_data = 32'h88888888;
        tick();
        spi_ready = 1'b0;
        chk("drop ic_ack", {30'd0, ic_ack, dc_ack}, 32'd2);
        tick();
        m_rdata = 32'h88888888;

        for (int n = 0; n < 40; n++) begin
            logic ic, dc, w, err;
            logic [19:0] ia, da, a;
            logic [31:0] d;
            ic = 1'($urandom_range(0, 1));
            dc = 1'($urandom_range(0, 1));
            if (!ic && !dc) ic = 1'b1;
            ia = 20'($urandom);
            da = 20'($urandom);
            case ($urandom_range(0, 3))
                0: ia = 20'hAFFFF;
                1: da = 20'hB0000;
                2: begin ia = 20'($urandom_range(0, 32'hAFFFF)); da = 20'($urandom_range(0, 32'hAFFFF)); end
                default: ;
            endcase
            d = $urandom;
            if (ic && dc) begin
                w = ~m_last;
                m_last = w;
            end else begin
                w = dc;
            end
            a = w ? da : ia;
            err = (a > 20'hAFFFF);
            if (!err) m_rdata = d;
            txn(ic, ia, dc, da, d, $urandom_range(0, 5), w, err, a, m_rdata, $sformatf("rnd%0d", n));
        end

        ic_req = 1'b1; ic_addr = 20'h00700;
        tick();
        ic_req = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        chk("abort outputs", {26'd0, busy, ic_ack, dc_ack, ic_err, dc_err, spi_req}, 32'd0);
        chk("abort rdata", rdata, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        spi_ready = 1'b1; spi_data = 32'hAAAA5555;
        tick();
        spi_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late ready", {27'd0, busy, ic_ack, dc_ack, ic_err, dc_err}, 32'd0);
            chk("late ready rdata", rdata, 32'd0);
            tick();
        end
        txn(1, 20'h00800, 1, 20'h00900, 32'hCAFEF00D, 1, 0, 0, 20'h00800, 32'hCAFEF00D, "post reset tie");

`ifdef FLASH_ARB_TIMEOUT_EN
        ic_req = 1'b1; ic_addr = 20'h00040;
        tick();
        ic_req = 1'b0;
        tick();
        repeat (15) @(posedge CLK);
        #1;
        chk("to wait16", {29'd0, busy, ic_err, ic_ack}, 32'd4);
        tick();
        chk("to ic_err", {29'd0, ic_err, ic_ack, dc_err}, 32'd4);
        tick();
        chk("to idle", {29'd0, busy, ic_err, spi_req}, 32'd0);

        ic_req = 1'b1; ic_addr = 20'h00050;
        tick();
        ic_req = 1'b0;
        tick();
        repeat (15) @(posedge CLK);
        #1;
        spi_ready = 1'b1; spi_data = 32'h12345678;
        tick();
        spi_ready = 1'b0;
        chk("to race ack", {30'd0, ic_ack, ic_err}, 32'd2);
        chk("to race rdata", rdata, 32'h12345678);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    always @(negedge CLK) begin
        if (resetn) begin
            chk("ack exclusive", 32'(ic_ack && dc_ack), 32'd0);
            chk("err exclusive", 32'(ic_err && dc_err), 32'd0);
        end
    end

endmodule
`default_nettype wire
